// File: rtl/decode_out_capture_fifo.sv
// Capture engine for LC3 decode-stage outputs: timestamps enabled samples, buffers them
// in a first-word-fall-through FIFO with registered head, counts drops and flags end-of-activity.
module decode_out_capture_fifo #(
    parameter int DEPTH        = 8,
    parameter int TS_W         = 16,
    parameter int CAPTURE_MODE = 0,
    parameter int STOP_ON_END  = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     en_de,
    input  logic [5:0]               e_cntrl,
    input  logic                     m_cntrl,
    input  logic [1:0]               w_cntrl,
    input  logic [15:0]              Instr_Reg,
    input  logic [15:0]              npc_out,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [40:0]              out_data,
    output logic [TS_W-1:0]          out_ts,
    output logic [$clog2(DEPTH):0]   count,
    output logic [7:0]               overflow_cnt,
    output logic                     stop
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int DATA_W = 41;
    localparam int ENT_W  = DATA_W + TS_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [TS_W-1:0]     ts_q, ts_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]      count_q, count_d;
    logic [7:0]          ovf_q, ovf_d;
    logic [DATA_W-1:0]   head_data_q, head_data_d;
    logic [TS_W-1:0]     head_ts_q, head_ts_d;
    logic                last_valid_q, last_valid_d;
    logic [31:0]         last_key_q, last_key_d;
    logic [ENT_W-1:0]    mem_q [DEPTH];

    logic [DATA_W-1:0]   sample;
    logic [31:0]         key;
    logic [PTR_W-1:0]    rd_next;
    logic                full;
    logic                empty;
    logic                pop;
    logic                candidate;
    logic                push_req;
    logic                push_ok;

    always_comb begin
        sample    = {e_cntrl, m_cntrl, w_cntrl, Instr_Reg, npc_out};
        key       = {Instr_Reg, npc_out};
        rd_next   = rd_ptr_q + 1'b1;
        full      = (count_q == (PTR_W+1)'(DEPTH));
        empty     = (count_q == '0);
        pop       = !empty && out_ready;
        candidate = en_de && !((state_q == ST_DONE) && (STOP_ON_END != 0));
        push_req  = candidate &&
                    ((CAPTURE_MODE == 0) || !last_valid_q || (key != last_key_q));
        // A full FIFO still accepts a push when the head leaves in the same cycle.
        push_ok   = push_req && (!full || pop);
    end

    always_comb begin
        ts_d         = ts_q + 1'b1;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        ovf_d        = ovf_q;
        head_data_d  = head_data_q;
        head_ts_d    = head_ts_q;
        last_valid_d = last_valid_q;
        last_key_d   = last_key_q;

        if (push_ok) begin
            wr_ptr_d     = wr_ptr_q + 1'b1;
            last_valid_d = 1'b1;
            last_key_d   = key;
        end else if (push_req && (ovf_q != 8'hFF)) begin
            ovf_d = ovf_q + 1'b1;
        end

        case ({push_ok, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // Head register follows the oldest entry; a lone entry popped alongside a push hands over to the new sample.
        if (pop) begin
            rd_ptr_d = rd_next;
            if (count_q > (PTR_W+1)'(1)) begin
                head_data_d = mem_q[rd_next][ENT_W-1:TS_W];
                head_ts_d   = mem_q[rd_next][TS_W-1:0];
            end else if (push_ok) begin
                head_data_d = sample;
                head_ts_d   = ts_q;
            end else begin
                head_data_d = '0;
                head_ts_d   = '0;
            end
        end else if (empty && push_ok) begin
            head_data_d = sample;
            head_ts_d   = ts_q;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (en_de)  state_d = ST_ACTIVE;
            ST_ACTIVE: if (!en_de) state_d = ST_DONE;
            ST_DONE:   state_d = ST_DONE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            ts_q         <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            ovf_q        <= '0;
            head_data_q  <= '0;
            head_ts_q    <= '0;
            last_valid_q <= 1'b0;
            last_key_q   <= '0;
        end else begin
            state_q      <= state_d;
            ts_q         <= ts_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            ovf_q        <= ovf_d;
            head_data_q  <= head_data_d;
            head_ts_q    <= head_ts_d;
            last_valid_q <= last_valid_d;
            last_key_q   <= last_key_d;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && push_ok) begin
            mem_q[wr_ptr_q] <= {sample, ts_q};
        end
    end

    assign out_valid    = !empty;
    assign out_data     = head_data_q;
    assign out_ts       = head_ts_q;
    assign count        = count_q;
    assign overflow_cnt = ovf_q;
    assign stop         = (state_q == ST_DONE);

endmodule

// File: tb/tb_decode_out_capture_fifo.sv
// Bench for decode_out_capture_fifo: two configurations driven in lockstep and
// compared every cycle against a queue-based reference model.
module tb_decode_out_capture_fifo;

    logic        clock;
    logic        reset;
    logic        en_de;
    logic [5:0]  e_cntrl;
    logic        m_cntrl;
    logic [1:0]  w_cntrl;
    logic [15:0] instr_reg;
    logic [15:0] npc;
    logic        out_ready;

    logic        a_valid, b_valid;
    logic [40:0] a_data, b_data;
    logic [15:0] a_ts;
    logic [3:0]  b_ts;
    logic [3:0]  a_count;
    logic [2:0]  b_count;
    logic [7:0]  a_ovf, b_ovf;
    logic        a_stop, b_stop;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Model configuration: index 0 mirrors dut_a, index 1 mirrors dut_b.
    int p_depth[2] = '{8, 4};
    int p_tsw[2]   = '{16, 4};
    int p_mode[2]  = '{0, 1};
    int p_soe[2]   = '{1, 0};

    logic [56:0] mq [2][$];
    int          mts[2];
    int          movf[2];
    bit          mact[2];
    bit          mdone[2];
    bit          mlv[2];
    logic [31:0] mlast[2];

    decode_out_capture_fifo #(
        .DEPTH(8), .TS_W(16), .CAPTURE_MODE(0), .STOP_ON_END(1)
    ) dut_a (
        .clock(clock), .reset(reset), .en_de(en_de),
        .e_cntrl(e_cntrl), .m_cntrl(m_cntrl), .w_cntrl(w_cntrl),
        .Instr_Reg(instr_reg), .npc_out(npc),
        .out_valid(a_valid), .out_ready(out_ready), .out_data(a_data),
        .out_ts(a_ts), .count(a_count), .overflow_cnt(a_ovf), .stop(a_stop)
    );

    decode_out_capture_fifo #(
        .DEPTH(4), .TS_W(4), .CAPTURE_MODE(1), .STOP_ON_END(0)
    ) dut_b (
        .clock(clock), .reset(reset), .en_de(en_de),
        .e_cntrl(e_cntrl), .m_cntrl(m_cntrl), .w_cntrl(w_cntrl),
        .Instr_Reg(instr_reg), .npc_out(npc),
        .out_valid(b_valid), .out_ready(out_ready), .out_data(b_data),
        .out_ts(b_ts), .count(b_count), .overflow_cnt(b_ovf), .stop(b_stop)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Spec-level behaviour: occupancy is a queue, stop is "saw enable, then saw it drop".
    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            bit          pop;
            bit          cand;
            bit          req;
            bit          full;
            logic [31:0] key;
            if (reset) begin
                mq[i].delete();
                mts[i]   = 0;
                movf[i]  = 0;
                mact[i]  = 0;
                mdone[i] = 0;
                mlv[i]   = 0;
                mlast[i] = '0;
            end else begin
                key  = {instr_reg, npc};
                pop  = (mq[i].size() > 0) && out_ready;
                cand = en_de && !(mdone[i] && (p_soe[i] != 0));
                req  = cand && ((p_mode[i] == 0) || !mlv[i] || (key != mlast[i]));
                full = (mq[i].size() == p_depth[i]);
                if (pop) void'(mq[i].pop_front());
                if (req) begin
                    if (!full || pop) begin
                        mq[i].push_back({e_cntrl, m_cntrl, w_cntrl, instr_reg, npc, 16'(mts[i])});
                        mlv[i]   = 1;
                        mlast[i] = key;
                    end else if (movf[i] < 255) begin
                        movf[i]++;
                    end
                end
                if (!mdone[i]) begin
                    if (mact[i] && !en_de) mdone[i] = 1;
                    else if (en_de) mact[i] = 1;
                end
                mts[i] = (mts[i] + 1) % (1 << p_tsw[i]);
            end
        end
    endtask

    task automatic checkOutput();
        logic [40:0] ed[2];
        logic [15:0] et[2];
        for (int i = 0; i < 2; i++) begin
            ed[i] = (mq[i].size() > 0) ? mq[i][0][56:16] : 41'd0;
            et[i] = (mq[i].size() > 0) ? mq[i][0][15:0]  : 16'd0;
        end
        chk("a.out_valid",    64'(a_valid), 64'(mq[0].size() > 0));
        chk("a.out_data",     64'(a_data),  64'(ed[0]));
        chk("a.out_ts",       64'(a_ts),    64'(et[0]));
        chk("a.count",        64'(a_count), 64'(mq[0].size()));
        chk("a.overflow_cnt", 64'(a_ovf),   64'(movf[0]));
        chk("a.stop",         64'(a_stop),  64'(mdone[0]));
        chk("b.out_valid",    64'(b_valid), 64'(mq[1].size() > 0));
        chk("b.out_data",     64'(b_data),  64'(ed[1]));
        chk("b.out_ts",       64'(b_ts),    64'(et[1]));
        chk("b.count",        64'(b_count), 64'(mq[1].size()));
        chk("b.overflow_cnt", 64'(b_ovf),   64'(movf[1]));
        chk("b.stop",         64'(b_stop),  64'(mdone[1]));
    endtask

    task automatic applyStimulus(input logic rst, input logic en, input logic rdy,
                                 input logic [15:0] ir, input logic [15:0] pc);
        reset     = rst;
        en_de     = en;
        out_ready = rdy;
        instr_reg = ir;
        npc       = pc;
        e_cntrl   = 6'($urandom);
        m_cntrl   = 1'($urandom);
        w_cntrl   = 2'($urandom);
        @(posedge clock);
        model_step();
        #1;
        checkOutput();
    endtask

    initial begin
        logic [15:0] basic_ir[4];
        logic [15:0] filt_ir[6];
        basic_ir = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
        filt_ir  = '{16'hAAAA, 16'hAAAA, 16'hBBBB, 16'hBBBB, 16'hBBBB, 16'hAAAA};

        $display("[TB] reset");
        applyStimulus(1, 1, 1, 16'h1111, 16'h2222);
        applyStimulus(1, 0, 0, 16'h0, 16'h0);
        chk("reset.a_valid", 64'(a_valid), 64'd0);
        chk("reset.b_stop",  64'(b_stop),  64'd0);

        $display("[TB] basic stream");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1, 1, basic_ir[i], 16'h3001 + 16'(i));
            chk("basic.ts",  64'(a_ts), 64'(i));
            chk("basic.key", 64'(a_data[31:0]), 64'({basic_ir[i], 16'h3001 + 16'(i)}));
            chk("basic.count_le1", 64'(a_count), 64'd1);
        end
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 16'h0, 16'h0);
        chk("basic.stop", 64'(a_stop), 64'd1);
        chk("basic.ovf",  64'(a_ovf),  64'd0);

        $display("[TB] overflow");
        applyStimulus(1, 0, 0, 16'h0, 16'h0);
        for (int i = 0; i < 10; i++) applyStimulus(0, 1, 0, 16'($urandom), 16'h4000 + 16'(i));
        chk("ovf.count", 64'(a_count), 64'd8);
        chk("ovf.cnt",   64'(a_ovf),   64'd2);
        applyStimulus(0, 1, 1, 16'hCAFE, 16'h4100);
        chk("ovf.full_pushpop_count", 64'(a_count), 64'd8);
        chk("ovf.full_pushpop_ovf",   64'(a_ovf),   64'd2);
        for (int i = 0; i < 10; i++) applyStimulus(0, 0, 1, 16'h0, 16'h0);
        chk("ovf.drained", 64'(a_count), 64'd0);

        $display("[TB] change filter");
        applyStimulus(1, 0, 0, 16'h0, 16'h0);
        for (int i = 0; i < 6; i++) applyStimulus(0, 1, 0, filt_ir[i], 16'h5000);
        chk("filter.count", 64'(b_count), 64'd3);
        chk("filter.ts0",   64'(b_ts),    64'd0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 16'h0, 16'h0);

        $display("[TB] end of activity");
        applyStimulus(1, 0, 0, 16'h0, 16'h0);
        applyStimulus(0, 1, 0, 16'h0101, 16'h6001);
        applyStimulus(0, 1, 0, 16'h0202, 16'h6002);
        applyStimulus(0, 0, 0, 16'h0303, 16'h6003);
        chk("eoa.stop", 64'(a_stop), 64'd1);
        applyStimulus(0, 1, 0, 16'h0404, 16'h6004);
        applyStimulus(0, 1, 0, 16'h0505, 16'h6005);
        chk("eoa.a_count", 64'(a_count), 64'd2);
        chk("eoa.b_count", 64'(b_count), 64'd4);

        $display("[TB] timestamp wrap");
        applyStimulus(1, 0, 0, 16'h0, 16'h0);
        for (int i = 0; i < 14; i++) applyStimulus(0, 0, 1, 16'h0, 16'h0);
        applyStimulus(0, 1, 1, 16'h0E0E, 16'h7000);
        chk("wrap.ts14", 64'(b_ts), 64'd14);
        applyStimulus(0, 1, 1, 16'h0F0F, 16'h7001);
        chk("wrap.ts15", 64'(b_ts), 64'd15);
        applyStimulus(0, 1, 1, 16'h1010, 16'h7002);
        chk("wrap.ts0",  64'(b_ts), 64'd0);

        $display("[TB] reset mid-operation");
        applyStimulus(1, 0, 0, 16'h0, 16'h0);
        for (int i = 0; i < 13; i++) applyStimulus(0, 1, 0, 16'h8000 + 16'(i), 16'h9000);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 1, 16'h0, 16'h0);
        chk("midrst.pre_count", 64'(a_count), 64'd3);
        chk("midrst.pre_ovf",   64'(a_ovf),   64'd5);
        chk("midrst.pre_stop",  64'(a_stop),  64'd1);
        applyStimulus(1, 1, 1, 16'hEEEE, 16'hEEEE);
        chk("midrst.count", 64'(a_count), 64'd0);
        chk("midrst.ovf",   64'(a_ovf),   64'd0);
        chk("midrst.stop",  64'(a_stop),  64'd0);
        chk("midrst.data",  64'(a_data),  64'd0);
        applyStimulus(0, 1, 0, 16'h4321, 16'h3000);
        chk("midrst.first_ts", 64'(a_ts),  64'd0);
        chk("midrst.first_cnt", 64'(a_count), 64'd1);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 39) == 0),
                          ($urandom_range(0, 3) != 0),
                          ($urandom_range(0, 2) != 0),
                          16'($urandom_range(0, 2)),
                          16'h3000 + 16'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/decode_out_capture_fifo.md
# decode_out_capture_fifo

- Synthesizable, parametrised capture engine for the LC3 decode-stage outputs.
- Each cycle `en_de` is high, it samples the decode control/instruction bundle and tags it with a free-running cycle timestamp.
- Entries are buffered in a first-word-fall-through FIFO and drained over a valid/ready port.
- It sits beside the decode stage and feeds on-chip trace/scoreboard logic. It adds change-only filtering, overflow accounting and end-of-activity detection.

## Interface
Parameters:
- DEPTH, 8 — FIFO entries; power of two, at least 2.
- TS_W, 16 — timestamp width in bits.
- CAPTURE_MODE, 0 — 0: capture every enabled cycle; 1: capture only when {Instr_Reg, npc_out} differs from the last pushed entry.
- STOP_ON_END, 1 — 1: no captures after end-of-activity; 0: keep capturing.

Ports:
- clock  in  1  — single clock, all logic on posedge.
- reset  in  1  — synchronous, active-high.
- en_de  in  1  — decode enable; a sample is a candidate only when high.
- e_cntrl  in  6  — execute control.
- m_cntrl  in  1  — memory control.
- w_cntrl  in  2  — writeback control.
- Instr_Reg  in  16  — decoded instruction.
- npc_out  in  16  — next PC.
- out_valid  out  1  — FIFO non-empty.
- out_ready  in  1  — consumer accepts head.
- out_data  out  41  — head entry, packed {e_cntrl, m_cntrl, w_cntrl, Instr_Reg, npc_out}, MSB first.
- out_ts  out  TS_W  — head entry timestamp.
- count  out  $clog2(DEPTH)+1  — current occupancy.
- overflow_cnt  out  8  — dropped-sample count; saturates at 255.
- stop  out  1  — sticky end-of-activity flag.

## Operation
- Timestamp counter: TS_W bits. Resets to 0, increments every cycle, wraps modulo 2^TS_W.
- Candidate at a posedge: en_de=1 AND NOT (stop AND STOP_ON_END).
  - CAPTURE_MODE=0: every candidate is a push request.
  - CAPTURE_MODE=1: a candidate is a push request only if the last-pushed flag is invalid or {Instr_Reg, npc_out} differs from the stored last-pushed value.
  - The last-pushed flag is cleared by reset.
- Push request handling:
  - Not full: the packed bundle and current timestamp are written at the tail.
  - Full and no pop in the same cycle: the sample is dropped and overflow_cnt increments, saturating at 255.
  - Full with a simultaneous pop: both the pop and the push succeed; count stays DEPTH.
- Last-pushed register updates only on a successful push. A dropped sample does not update it.
- Pop: out_valid AND out_ready at a posedge. out_ready while empty is ignored.
- Pointers are $clog2(DEPTH) bits and wrap naturally. count is the true occupancy, from 0 to DEPTH.
- End-of-activity FSM:
  - IDLE → ACTIVE when en_de=1.
  - ACTIVE → DONE when en_de=0.
  - DONE holds until reset.
  - stop = (state == DONE).
  - A candidate in the cycle en_de falls does not exist, since en_de is low.
- The FIFO keeps draining after stop is set.

## Timing
- Reset values:
  - out_valid=0, out_data=0, out_ts=0, count=0, overflow_cnt=0, stop=0.
  - FSM=IDLE, timestamp=0, FIFO pointers=0.
- Sample-to-output latency is 1 cycle. A push at edge N makes out_valid=1 and out_data/out_ts the entry after edge N, when the FIFO was empty.
- out_data and out_ts are registered head values. They change only on a push into an empty FIFO or on a pop, and are 0 when empty.
- Timestamp: a sample taken at edge N carries the counter value present before edge N. With no stall since reset, the first enabled cycle after reset deassertion stores ts=0 if en_de is high in that first cycle.
- stop asserts 1 cycle after the first edge where en_de=0 follows en_de=1.
- Reset mid-operation:
  - All content is discarded and every output returns to its reset value on the next edge.
  - Inputs sampled at that edge are ignored.
- count and overflow_cnt update on the same edge as the push/pop they reflect.

## Test plan
- Basic stream, DEPTH=8, mode 0, out_ready=1:
  - Stimulus: en_de high for 4 cycles with Instr_Reg=0x1234,0x5678,0x9ABC,0xDEF0 and npc=0x3001..0x3004.
  - Required: 4 pops in order with out_ts=0,1,2,3; count never exceeds 1; overflow_cnt=0.
- Overflow:
  - Stimulus: out_ready=0, 10 enabled cycles.
  - Required: count=8; overflow_cnt=2. Draining returns the first 8 samples in order.
  - Then with the FIFO full, assert out_ready and push in the same cycle. Required: count stays 8, the new entry lands at the tail, overflow_cnt stays 2.
- Change filter, mode 1:
  - Stimulus: 6 enabled cycles with IR/npc = A,A,B,B,B,A.
  - Required: exactly 3 entries, A, B, A, with timestamps of the 1st, 3rd and 6th cycles.
- End of activity, STOP_ON_END=1:
  - Stimulus: en_de 1,1,0,1,1.
  - Required: stop=1 one cycle after en_de falls; only 2 entries captured. With STOP_ON_END=0, 4 entries are captured.
- Timestamp wrap, TS_W=4:
  - Stimulus: enable at counter 14, 15, 0.
  - Required: out_ts=14, 15, 0.
- Reset mid-operation:
  - Stimulus: 3 entries queued, overflow_cnt=5, stop=1, then pulse reset for 1 cycle.
  - Required: all outputs 0, FSM IDLE, and the next enabled sample gets ts=0.
